frame_deframer: RTL and testbench

- Parametrised next-generation input stage: takes a word stream of sync, channel, payload, CRC and tail words, and checks the CRC internally.
- Delivers each good frame as one left-aligned packed word on a valid/ready output toward the channel FIFO.
- Compared with the previous generation it adds:
  - parametrised word width, depth and header/tail patterns;
  - an input qualifier;
  - output backpressure;
  - length and overflow error reporting.

---
 rtl/frame_deframer.sv | 243 ++++++++++++++++++++++++
 tb/tb_frame_deframer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_deframer.sv
// Word-stream deframer: hunts SYNC,SYNC, takes a channel word, collects payload up to TAIL,TAIL,
// checks the CRC and presents each good frame left-aligned on a valid/ready output. Optional counters: FRAME_STATS_EN.
module frame_deframer #(
    parameter int                DATA_W    = 16,
    parameter int                CH_W      = 8,
    parameter int                MAX_WORDS = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = 16'hE0E0,
    parameter logic [DATA_W-1:0] TAIL_WORD = 16'h0E0E,
    parameter logic [DATA_W-1:0] CRC_POLY  = 16'h1021,
    parameter logic [DATA_W-1:0] CRC_INIT  = 16'hFFFF,
    localparam int               LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic [MAX_WORDS*DATA_W-1:0]   out_data,
    output logic [CH_W-1:0]               out_ch,
    output logic [LEN_W-1:0]              out_len,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          crc_err,
    output logic                          len_err,
    output logic                          ovf_err,
    output logic [15:0]                   frame_cnt,
    output logic [15:0]                   err_cnt
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_CHAN = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_WORDS);

    function automatic logic [DATA_W-1:0] crc_step(input logic [DATA_W-1:0] crc,
                                                   input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] c;
        c = crc;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (c[DATA_W-1] ^ data[i]) begin
                c = {c[DATA_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[DATA_W-2:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t                        r_state;
    logic                          r_sync_hit;
    logic [CH_W-1:0]               r_ch;
    logic [DATA_W-1:0]             r_crc;
    logic [LEN_W-1:0]              r_cnt;
    logic [1:0]                    r_fill;
    logic [DATA_W-1:0]             r_win [3];
    logic [MAX_WORDS*DATA_W-1:0]   r_out_data;
    logic [CH_W-1:0]               r_out_ch;
    logic [LEN_W-1:0]              r_out_len;
    logic                          r_out_valid;
    logic                          r_crc_err;
    logic                          r_len_err;
    logic                          r_ovf_err;

    logic                          w_is_sync;
    logic                          w_is_tail;
    logic                          w_body;
    logic                          w_start;
    logic                          w_full;
    logic                          w_cnt_max;
    logic                          w_term;
    logic                          w_commit;
    logic [DATA_W-1:0]             w_crc_next;
    logic                          w_crc_ok;
    logic                          w_len_bad;
    logic                          w_crc_bad;
    logic                          w_good;
    logic                          w_load;
    logic                          w_ovf;
    logic [MAX_WORDS*DATA_W-1:0]   w_frame;

    assign w_is_sync = (in_data == SYNC_WORD);
    assign w_is_tail = (in_data == TAIL_WORD);
    assign w_body    = (r_state == ST_BODY) && in_valid;
    assign w_start   = (r_state == ST_CHAN) && in_valid && !w_is_sync;
    assign w_full    = (r_fill == 2'd3);
    assign w_cnt_max = (r_cnt == MAX_CNT);

    // Window: r_win[0] oldest (next payload word), r_win[1] CRC candidate, r_win[2] newest.
    assign w_term     = w_body && w_is_tail && (r_fill != 2'd0) && (r_win[2] == TAIL_WORD);
    assign w_commit   = w_body && w_full && !w_cnt_max && !w_term;
    assign w_crc_next = crc_step(r_crc, r_win[0]);
    assign w_crc_ok   = (w_crc_next == r_win[1]);

    // Exactly one outcome per terminated frame; over-long also fires without a tail pair.
    assign w_len_bad = w_body && ((w_full && w_cnt_max) || (w_term && !w_full));
    assign w_crc_bad = w_term && w_full && !w_cnt_max && !w_crc_ok;
    assign w_good    = w_term && w_full && !w_cnt_max && w_crc_ok;
    assign w_load    = w_good && (!r_out_valid || out_ready);
    assign w_ovf     = w_good && r_out_valid && !out_ready;

    // Payload slots; the last payload word is still in the window at termination and is merged in here.
    for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_slot
        logic [DATA_W-1:0] r_word;

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_word <= '0;
            end else if (w_start) begin
                r_word <= '0;
            end else if (w_commit && (r_cnt == LEN_W'(gi))) begin
                r_word <= r_win[0];
            end
        end

        assign w_frame[(MAX_WORDS-1-gi)*DATA_W +: DATA_W] =
            (r_cnt == LEN_W'(gi)) ? r_win[0] : r_word;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_sync_hit  <= 1'b0;
            r_ch        <= '0;
            r_crc       <= '0;
            r_cnt       <= '0;
            r_fill      <= '0;
            r_win[0]    <= '0;
            r_win[1]    <= '0;
            r_win[2]    <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_len   <= '0;
            r_out_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            r_len_err   <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_crc_err <= 1'b0;
            r_len_err <= 1'b0;
            r_ovf_err <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_HUNT: begin
                    if (in_valid) begin
                        if (w_is_sync) begin
                            r_sync_hit <= 1'b1;
                            if (r_sync_hit) begin
                                r_sync_hit <= 1'b0;
                                r_state    <= ST_CHAN;
                            end
                        end else begin
                            r_sync_hit <= 1'b0;
                        end
                    end
                end

                // Extra sync words are absorbed here; the first non-sync word is the channel.
                ST_CHAN: begin
                    if (w_start) begin
                        r_ch    <= in_data[CH_W-1:0];
                        r_crc   <= CRC_INIT;
                        r_cnt   <= '0;
                        r_fill  <= '0;
                        r_state <= ST_BODY;
                    end
                end

                ST_BODY: begin
                    if (in_valid) begin
                        if (w_len_bad) begin
                            r_len_err <= 1'b1;
                            r_state   <= ST_HUNT;
                        end else if (w_crc_bad) begin
                            r_crc_err <= 1'b1;
                            r_state   <= ST_HUNT;
                        end else if (w_load) begin
                            r_out_data  <= w_frame;
                            r_out_ch    <= r_ch;
                            r_out_len   <= r_cnt + LEN_W'(1);
                            r_out_valid <= 1'b1;
                            r_state     <= ST_HUNT;
                        end else if (w_ovf) begin
                            r_ovf_err <= 1'b1;
                            r_state   <= ST_HUNT;
                        end else begin
                            r_win[0] <= r_win[1];
                            r_win[1] <= r_win[2];
                            r_win[2] <= in_data;
                            if (!w_full) begin
                                r_fill <= r_fill + 2'd1;
                            end else begin
                                r_crc <= w_crc_next;
                                r_cnt <= r_cnt + LEN_W'(1);
                            end
                        end
                    end
                end

                default: r_state <= ST_HUNT;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_len   = r_out_len;
    assign out_valid = r_out_valid;
    assign crc_err   = r_crc_err;
    assign len_err   = r_len_err;
    assign ovf_err   = r_ovf_err;

`ifdef FRAME_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    // At most one error event can occur per cycle, so a single increment suffices.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_load && (r_frame_cnt != 16'hFFFF)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if ((w_len_bad || w_crc_bad || w_ovf) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_frame_deframer.sv
// Bench for frame_deframer: directed frames plus randomized frames against a frame-level reference model.
module tb_frame_deframer;

    localparam int          DW   = 16;
    localparam int          MAXW = 8;
    localparam int          LW   = 4;
    localparam int          OW   = MAXW * DW;
    localparam logic [15:0] SYNC = 16'hE0E0;
    localparam logic [15:0] TAIL = 16'h0E0E;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic [7:0]    out_ch;
    logic [LW-1:0] out_len;
    logic          out_valid;
    logic          crc_err;
    logic          len_err;
    logic          ovf_err;
    logic [15:0]   frame_cnt;
    logic [15:0]   err_cnt;

    always #5 clk_in = ~clk_in;

    frame_deframer dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .crc_err   (crc_err),
        .len_err   (len_err),
        .ovf_err   (ovf_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pulse monitor, sampled mid-cycle.
    int seen_crc = 0;
    int seen_len = 0;
    int seen_ovf = 0;
    always @(negedge clk_in) begin
        if (rst_n) begin
            if (crc_err) seen_crc <= seen_crc + 1;
            if (len_err) seen_len <= seen_len + 1;
            if (ovf_err) seen_ovf <= seen_ovf + 1;
        end
    end

    // Reference model state.
    int            exp_crc  = 0;
    int            exp_len  = 0;
    int            exp_ovf  = 0;
    bit            m_held   = 0;
    logic [OW-1:0] m_data   = '0;
    logic [7:0]    m_ch     = '0;
    int            m_len    = 0;
    int            m_frames = 0;
    int            m_errs   = 0;
    logic [15:0]   pl_q[$];

    // CRC-16 over the payload viewed as one MSB-first bit stream.
    function automatic logic [15:0] ref_crc();
        logic [15:0] r;
        bit          fb;
        r = 16'hFFFF;
        foreach (pl_q[i]) begin
            for (int b = 15; b >= 0; b--) begin
                fb = r[15] ^ pl_q[i][b];
                r  = r << 1;
                if (fb) r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] ref_pack();
        logic [OW-1:0] v;
        v = '0;
        foreach (pl_q[i]) v[(MAXW-1-i)*DW +: DW] = pl_q[i];
        return v;
    endfunction

    task automatic drive_word(input logic [15:0] w, input bit gaps, input bit rdy);
        if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
                in_valid  = 1'b0;
                in_data   = 16'($urandom);
                out_ready = rdy;
                @(posedge clk_in); #1;
            end
        end
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = rdy;
        @(posedge clk_in); #1;
    endtask

    task automatic check_stats(input string name);
`ifdef FRAME_STATS_EN
        chk({name, ".frame_cnt"}, OW'(frame_cnt), OW'(m_frames));
        chk({name, ".err_cnt"}, OW'(err_cnt), OW'(m_errs));
`else
        chk({name, ".frame_cnt"}, OW'(frame_cnt), OW'(0));
        chk({name, ".err_cnt"}, OW'(err_cnt), OW'(0));
`endif
    endtask

    task automatic send_frame(input logic [15:0] ch_word, input logic [15:0] crc_word,
                              input int nsync, input bit gaps, input bit rdy,
                              input bit rdy_last, input string name);
        int          n;
        bit          load;
        string       verdict;
        logic [15:0] wq[$];
        n    = pl_q.size();
        load = 0;
        for (int i = 0; i < nsync; i++) wq.push_back(SYNC);
        wq.push_back(ch_word);
        foreach (pl_q[i]) wq.push_back(pl_q[i]);
        wq.push_back(crc_word);
        wq.push_back(TAIL);
        wq.push_back(TAIL);

        if (rdy) m_held = 0;
        if (n == 0 || n > MAXW) begin
            exp_len++; m_errs++; verdict = "len_err";
        end else if (crc_word != ref_crc()) begin
            exp_crc++; m_errs++; verdict = "crc_err";
        end else if (!m_held || rdy_last) begin
            load = 1; verdict = "deliver";
        end else begin
            exp_ovf++; m_errs++; verdict = "ovf_err";
        end
        if (load) begin
            m_held = 1; m_data = ref_pack(); m_ch = ch_word[7:0]; m_len = n; m_frames++;
        end else if (rdy_last) begin
            m_held = 0;
        end

        foreach (wq[i]) drive_word(wq[i], gaps, (i == wq.size() - 1) ? rdy_last : rdy);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (load) chk({name, ".latency"}, OW'(out_valid), OW'(1));
        repeat (2) @(posedge clk_in);
        #1;
        chk({name, ".crc_pulses"}, OW'(seen_crc), OW'(exp_crc));
        chk({name, ".len_pulses"}, OW'(seen_len), OW'(exp_len));
        chk({name, ".ovf_pulses"}, OW'(seen_ovf), OW'(exp_ovf));
        chk({name, ".out_valid"}, OW'(out_valid), OW'(m_held));
        if (m_held) begin
            chk({name, ".out_data"}, out_data, m_data);
            chk({name, ".out_ch"}, OW'(out_ch), OW'(m_ch));
            chk({name, ".out_len"}, OW'(out_len), OW'(m_len));
        end
        check_stats(name);
        $display("frame %s: n=%0d ch=%h crcw=%h rdy=%0b/%0b -> %s", name, n, ch_word, crc_word,
                 rdy, rdy_last, verdict);
    endtask

    task automatic accept_out(input string name);
        out_ready = 1'b1;
        @(posedge clk_in); #1;
        out_ready = 1'b0;
        m_held = 0;
        chk({name, ".out_valid"}, OW'(out_valid), OW'(0));
        $display("accept %s", name);
    endtask

    task automatic random_frame(input int idx);
        int          n;
        int          r;
        bit          good;
        logic [15:0] w;
        logic [15:0] ch;
        logic [15:0] cw;
        n = $urandom_range(0, 10);
        pl_q.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                w = SYNC;
            end else if (r == 1 && (i == 0 || pl_q[i-1] != TAIL)) begin
                w = TAIL;
            end else begin
                do w = 16'($urandom); while (w == SYNC || w == TAIL);
            end
            pl_q.push_back(w);
        end
        good = ($urandom_range(0, 3) != 0);
        cw   = good ? ref_crc() : (ref_crc() ^ (16'h1 << $urandom_range(0, 14)));
        if (cw == TAIL) cw = cw ^ 16'h8000;
        do ch = 16'($urandom); while (ch == SYNC);
        send_frame(ch, cw, $urandom_range(2, 4), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", idx));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset.out_valid", OW'(out_valid), OW'(0));
        chk("reset.out_data", out_data, OW'(0));
        chk("reset.out_len", OW'(out_len), OW'(0));
        chk("reset.crc_err", OW'(crc_err), OW'(0));
        chk("reset.len_err", OW'(len_err), OW'(0));
        chk("reset.ovf_err", OW'(ovf_err), OW'(0));
        chk("reset.frame_cnt", OW'(frame_cnt), OW'(0));
        rst_n = 1'b1;
        @(posedge clk_in); #1;

        // Reference stream from the plan, absolute expected values.
        pl_q = '{16'h0000};
        send_frame(16'h0005, 16'h1D0F, 2, 0, 0, 0, "tp_good");
        chk("tp_good.abs_data", out_data, {16'h0000, 112'h0});
        chk("tp_good.abs_ch", OW'(out_ch), OW'(8'h05));
        chk("tp_good.abs_len", OW'(out_len), OW'(1));
        accept_out("tp_good");

        send_frame(16'h0005, 16'h1D0E, 2, 0, 0, 0, "tp_badcrc");
        send_frame(16'h0005, 16'h1D0F, 2, 0, 0, 0, "tp_after_bad");
        accept_out("tp_after_bad");

        pl_q.delete();
        send_frame(16'h0001, 16'h1D0F, 2, 0, 0, 0, "zero_len");

        pl_q.delete();
        for (int i = 0; i < 9; i++) pl_q.push_back(16'h1000 + 16'(i));
        send_frame(16'h0002, ref_crc(), 2, 0, 0, 0, "over_long9");

        pl_q.delete();
        for (int i = 0; i < MAXW; i++) pl_q.push_back(16'h2000 + 16'(i));
        send_frame(16'h0003, ref_crc(), 3, 0, 0, 0, "full_len");

        pl_q = '{16'h1234, SYNC, TAIL, 16'h5678};
        send_frame(16'h0004, ref_crc(), 2, 0, 0, 0, "held_ovf");
        accept_out("held_ovf");

        // Two good frames with backpressure: second must overflow, first stays put.
        pl_q = '{16'hABCD, 16'h0101};
        send_frame(16'h0011, ref_crc(), 2, 0, 0, 0, "bp_first");
        pl_q = '{16'h7777};
        send_frame(16'h0022, ref_crc(), 2, 0, 0, 0, "bp_second");
        accept_out("bp_release");

        pl_q = '{16'h0000};
        send_frame(16'h0005, 16'h1D0F, 2, 1, 0, 0, "tp_gaps");
        pl_q = '{16'hBEEF, 16'hCAFE, 16'hF00D};
        send_frame(16'h0033, ref_crc(), 4, 1, 0, 1, "accept_same_cycle");
        accept_out("accept_same_cycle");

        // Reset in the middle of a payload.
        drive_word(SYNC, 0, 0);
        drive_word(SYNC, 0, 0);
        drive_word(16'h0044, 0, 0);
        drive_word(16'h1111, 0, 0);
        drive_word(16'h2222, 0, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        m_held   = 0;
        m_frames = 0;
        m_errs   = 0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("mid_reset.out_valid", OW'(out_valid), OW'(0));
        chk("mid_reset.len_err", OW'(len_err), OW'(0));
        rst_n = 1'b1;
        @(posedge clk_in); #1;
        $display("reset mid-payload");
        pl_q = '{16'h0000};
        send_frame(16'h0005, 16'h1D0F, 2, 0, 0, 0, "post_reset");

        for (int k = 0; k < 40; k++) random_frame(k);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
